// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Issues one data-memory transaction per load/store over a valid/ready
// request bus, waits for the response, formats load data and registers
// the MEM/WB outputs. Non-memory ops pass through with 1-cycle latency.
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned H/W accesses
// raise misalign_o instead of being issued to memory).
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // EX/MEM register
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_alu_result_i,
    input  logic [XLEN-1:0] ex_rs2_data_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_mem_write_i,
    input  logic [2:0]      ex_funct3_i,
    output logic            stall_o,
    // data-memory bus
    output logic            dmem_req_valid_o,
    input  logic            dmem_req_ready_i,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_rsp_valid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    // MEM/WB register
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_result_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic            wb_reg_write_o,
    // misalignment trap
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request / instruction fields, held stable for the whole transaction
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_reg_write;

    // MEM/WB registers
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_result;
    logic [4:0]      r_wb_rd;
    logic            r_wb_reg_write;

    logic            w_mem_op;
    logic            w_misalign;
    logic            w_issue;
    logic            w_rsp;
    logic            w_stall;
    logic            w_req_valid;

    // Byte enables: funct3[1:0] gives the size (00 B, 01 H, otherwise W).
    function automatic logic [3:0] f_store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across all lanes so the byte enables alone pick the lane.
    function automatic logic [XLEN-1:0] f_store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] wd;
        wd = d;
        case (f3[1:0])
            2'b00:   wd = {4{d[7:0]}};
            2'b01:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    // Load formatting: shift the addressed lane down, then sign- or zero-extend.
    // Halfwords only look at off[1]; words ignore the offset entirely.
    function automatic logic [XLEN-1:0] f_load_format(input logic [2:0] f3, input logic [1:0] off,
                                                      input logic [XLEN-1:0] word);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh  = word;
        res = word;
        case (f3[1:0])
            2'b00: begin
                sh  = word >> {off, 3'b000};
                res = f3[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = word >> {off[1], 4'b0000};
                res = f3[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Halfword at an odd address or word at a non-multiple-of-4 address.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    assign w_mem_op = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op & f_misaligned(ex_funct3_i, ex_alu_result_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_misalign;
    // The response is only meaningful while waiting; a late one after an abort is dropped.
    assign w_rsp   = (r_state == ST_WAIT) & dmem_rsp_valid_i;

    // Next-state, stall and request-valid decode
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                if (dmem_req_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Release upstream in the response cycle so the next instruction
                // arrives exactly as this one retires into MEM/WB.
                if (w_rsp) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the request fields when a memory op is accepted from EX/MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_issue) begin
            r_addr      <= ex_alu_result_i;
            r_we        <= ex_mem_write_i;
            r_be        <= ex_mem_write_i ? f_store_be(ex_funct3_i, ex_alu_result_i[1:0]) : 4'b1111;
            r_wdata     <= f_store_wdata(ex_funct3_i, ex_rs2_data_i);
            r_funct3    <= ex_funct3_i;
            r_rd        <= ex_rd_addr_i;
            r_reg_write <= ex_reg_write_i;
        end
    end

    // MEM/WB register: pass-through in IDLE, bubble while a transaction is open, retire on response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_result    <= '0;
            r_wb_rd        <= 5'd0;
            r_wb_reg_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_wb_valid     <= 1'b0;
                        r_wb_reg_write <= 1'b0;
                    end else begin
                        r_wb_valid     <= ex_valid_i;
                        r_wb_result    <= ex_alu_result_i;
                        r_wb_rd        <= ex_rd_addr_i;
                        r_wb_reg_write <= ex_valid_i & ex_reg_write_i;
                    end
                end
                ST_WAIT: begin
                    if (w_rsp) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_result    <= r_we ? r_addr : f_load_format(r_funct3, r_addr[1:0], dmem_rdata_i);
                        r_wb_rd        <= r_rd;
                        // Stores retire without a register write.
                        r_wb_reg_write <= r_reg_write & ~r_we;
                    end else begin
                        r_wb_valid     <= 1'b0;
                        r_wb_reg_write <= 1'b0;
                    end
                end
                default: begin
                    r_wb_valid     <= 1'b0;
                    r_wb_reg_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;

    // One-cycle trap pulse; the offending address is held until the next trap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= (r_state == ST_IDLE) & w_misalign;
            if ((r_state == ST_IDLE) && w_misalign) begin
                r_misalign_addr <= ex_alu_result_i;
            end
        end
    end

    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_misalign_addr;
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

    assign stall_o          = w_stall;
    assign dmem_req_valid_o = w_req_valid;
    assign dmem_addr_o      = {r_addr[XLEN-1:2], 2'b00};
    assign dmem_we_o        = r_we;
    assign dmem_be_o        = r_be;
    assign dmem_wdata_o     = r_wdata;

    assign wb_valid_o     = r_wb_valid;
    assign wb_result_o    = r_wb_result;
    assign wb_rd_addr_o   = r_wb_rd;
    assign wb_reg_write_o = r_wb_reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. A stimulus process acts as the
// upstream pipeline (honouring stall_o), a responder models data memory with
// random ready/response timing, and a monitor compares every request and every
// MEM/WB output against expectations computed from the access rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [31:0] ex_alu_result_i;
    logic [31:0] ex_rs2_data_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_reg_write_i;
    logic        ex_mem_read_i;
    logic        ex_mem_write_i;
    logic [2:0]  ex_funct3_i;
    logic        stall_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_reg_write_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_i       (ex_valid_i),
        .ex_alu_result_i  (ex_alu_result_i),
        .ex_rs2_data_i    (ex_rs2_data_i),
        .ex_rd_addr_i     (ex_rd_addr_i),
        .ex_reg_write_i   (ex_reg_write_i),
        .ex_mem_read_i    (ex_mem_read_i),
        .ex_mem_write_i   (ex_mem_write_i),
        .ex_funct3_i      (ex_funct3_i),
        .stall_o          (stall_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_result_o      (wb_result_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_reg_write_o   (wb_reg_write_o),
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] result;
        logic        chk_result;
        logic [4:0]  rd;
        logic        rw;
    } wb_t;

    logic [31:0] mem [256];
    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [31:0] mis_q[$];
    int          checks = 0;
    int          errors = 0;
    int          long_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data-memory responder: random ready, response 0..2 extra cycles after accept
    initial begin
        logic        hs;
        logic [31:0] haddr;
        logic [31:0] paddr;
        logic        pend;
        int          dly;
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        dmem_rdata_i     = 32'h0;
        pend  = 1'b0;
        dly   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clk);
            hs    = dmem_req_valid_o && dmem_req_ready_i;
            haddr = dmem_addr_o;
            @(posedge clk);
            #1;
            dmem_rsp_valid_i = 1'b0;
            dmem_rdata_i     = $urandom;
            if (hs) begin
                pend  = 1'b1;
                paddr = haddr;
                dly   = (long_delay != 0) ? long_delay : $urandom_range(0, 2);
            end
            if (pend) begin
                if (dly == 0) begin
                    dmem_rsp_valid_i = 1'b1;
                    dmem_rdata_i     = mem[paddr[9:2]];
                    pend             = 1'b0;
                end else begin
                    dly--;
                end
            end
            dmem_req_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares requests while presented and MEM/WB outputs when valid
    initial begin
        req_t        er;
        wb_t         ew;
        logic [31:0] ma;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dmem_req_valid_o) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr_o);
                    end else begin
                        er = req_q[0];
                        check("req_addr", dmem_addr_o, er.addr);
                        check("req_we", {31'b0, dmem_we_o}, {31'b0, er.we});
                        check("req_be", {28'b0, dmem_be_o}, {28'b0, er.be});
                        if (er.we) check("req_wdata", dmem_wdata_o, er.wdata);
                        if (dmem_req_ready_i) void'(req_q.pop_front());
                    end
                end
                if (wb_valid_o) begin
                    if (wb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wb: got result %h expected no writeback", wb_result_o);
                    end else begin
                        ew = wb_q.pop_front();
                        if (ew.chk_result) check("wb_result", wb_result_o, ew.result);
                        check("wb_rd", {27'b0, wb_rd_addr_o}, {27'b0, ew.rd});
                        check("wb_reg_write", {31'b0, wb_reg_write_o}, {31'b0, ew.rw});
`ifndef MEM_MISALIGN_TRAP_EN
                        check("misalign_tied", {31'b0, misalign_o}, 32'h0);
`endif
                    end
                end
`ifdef MEM_MISALIGN_TRAP_EN
                if (misalign_o) begin
                    if (mis_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_misalign: got addr %h expected none", misalign_addr_o);
                    end else begin
                        ma = mis_q.pop_front();
                        check("misalign_addr", misalign_addr_o, ma);
                        check("misalign_wb_reg_write", {31'b0, wb_reg_write_o}, 32'h0);
                    end
                end
`endif
            end
        end
    end

    // Present one instruction upstream, push its expected effects, hold it while stalled
    task automatic issue(input logic v, input logic rd_f, input logic wr_f, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw);
        int          sz;
        int          off;
        int          ofs;
        logic        mis;
        logic        trap;
        logic        memop;
        logic [31:0] word;
        logic [31:0] val;
        req_t        r;
        wb_t         w;
        int          nst;
        logic        s;
        sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off = int'(alu[1:0]);
        mis = (sz == 2 && (off % 2) == 1) || (sz == 4 && off != 0);
`ifdef MEM_MISALIGN_TRAP_EN
        trap = v && (rd_f || wr_f) && mis;
`else
        trap = 1'b0;
`endif
        memop = v && (rd_f || wr_f) && !trap;
        if (trap) begin
            mis_q.push_back(alu);
        end else if (memop) begin
            r.addr  = alu & 32'hFFFF_FFFC;
            r.we    = wr_f;
            r.be    = 4'hF;
            r.wdata = rs2;
            w.rd    = rd;
            if (wr_f) begin
                r.be    = (sz == 1) ? (4'b0001 << off) : (sz == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
                r.wdata = (sz == 1) ? rs2[7:0] * 32'h0101_0101 : (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
                w.result     = 32'h0;
                w.chk_result = 1'b0;
                w.rw         = 1'b0;
            end else begin
                word = mem[alu[9:2]];
                ofs  = (sz == 1) ? off : (sz == 2) ? (off / 2) * 2 : 0;
                val  = word >> (8 * ofs);
                if (sz == 1) begin
                    val = val & 32'hFF;
                    if (f3 == 3'd0 && val >= 32'd128) val = val + 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    val = val & 32'hFFFF;
                    if (f3 == 3'd1 && val >= 32'd32768) val = val + 32'hFFFF_0000;
                end
                w.result     = val;
                w.chk_result = 1'b1;
                w.rw         = rw;
            end
            req_q.push_back(r);
            wb_q.push_back(w);
        end else if (v) begin
            w.result     = alu;
            w.chk_result = 1'b1;
            w.rd         = rd;
            w.rw         = rw;
            wb_q.push_back(w);
        end
        ex_valid_i      = v;
        ex_mem_read_i   = rd_f;
        ex_mem_write_i  = wr_f;
        ex_funct3_i     = f3;
        ex_alu_result_i = alu;
        ex_rs2_data_i   = rs2;
        ex_rd_addr_i    = rd;
        ex_reg_write_i  = rw;
        nst = 0;
        forever begin
            @(negedge clk);
            s = stall_o;
            @(posedge clk);
            #1;
            if (!s) break;
            nst++;
            if (nst > 40) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got %0d stall cycles expected at most 40", nst);
                break;
            end
        end
        if (memop) check("mem_stall_min2", {31'b0, nst >= 2}, 32'h1);
        else       check("no_stall", nst, 0);
        ex_valid_i = 1'b0;
    endtask

    initial begin
        logic [2:0] lf [5];
        logic [2:0] sf [6];
        int         k;
        int         n;
        logic       b;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        sf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[32'h100 >> 2] = 32'h0080_0000;

        rst             = 1'b1;
        ex_valid_i      = 1'b0;
        ex_alu_result_i = 32'h0;
        ex_rs2_data_i   = 32'h0;
        ex_rd_addr_i    = 5'd0;
        ex_reg_write_i  = 1'b0;
        ex_mem_read_i   = 1'b0;
        ex_mem_write_i  = 1'b0;
        ex_funct3_i     = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'b0, stall_o}, 32'h0);
        check("rst_req_valid", {31'b0, dmem_req_valid_o}, 32'h0);
        check("rst_wb_valid", {31'b0, wb_valid_o}, 32'h0);
        check("rst_wb_reg_write", {31'b0, wb_reg_write_o}, 32'h0);
        check("rst_wb_result", wb_result_o, 32'h0);
        check("rst_dmem_addr", dmem_addr_o, 32'h0);
        check("rst_dmem_be", {28'b0, dmem_be_o}, 32'h0);
        check("rst_misalign", {31'b0, misalign_o}, 32'h0);
        @(posedge clk);
        #1;

        // Directed: ADD pass-through, SB lane, LB/LBU sign handling, misaligned LW
        issue(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1);
        issue(1'b1, 1'b0, 1'b1, 3'd0, 32'h103, 32'hAABB_CCDD, 5'd7, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 5'd3, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd4, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 5'd9, 1'b1);
        issue(1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd9, 1'b1);

        // Randomised mix of ALU ops, loads, stores and invalid slots
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            if (k < 3) begin
                issue(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else if (k < 6) begin
                issue(1'b1, 1'b1, 1'b0, lf[$urandom_range(0, 4)], 32'($urandom_range(0, 1023)), $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else if (k < 9) begin
                issue(1'b1, 1'b0, 1'b1, sf[$urandom_range(0, 5)], 32'($urandom_range(0, 1023)), $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                b = 1'($urandom_range(0, 1));
                issue(1'b0, b, !b, 3'd2, 32'($urandom_range(0, 1023)), $urandom,
                      5'($urandom_range(0, 31)), 1'b1);
            end
        end

        // Reset while waiting for a response; the late response must be ignored
        repeat (4) @(posedge clk);
        #1;
        req_q.delete();
        long_delay = 3;
        begin
            req_t r;
            r.addr  = 32'h40;
            r.we    = 1'b0;
            r.be    = 4'hF;
            r.wdata = 32'h0;
            req_q.push_back(r);
        end
        ex_valid_i      = 1'b1;
        ex_mem_read_i   = 1'b1;
        ex_mem_write_i  = 1'b0;
        ex_funct3_i     = 3'd2;
        ex_alu_result_i = 32'h40;
        ex_rd_addr_i    = 5'd1;
        ex_reg_write_i  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (dmem_req_valid_o && dmem_req_ready_i) break;
            n++;
            if (n > 30) begin
                checks++;
                errors++;
                $display("FAIL abort_req_timeout: got no accepted request expected one within 30 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        long_delay = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_req_valid", {31'b0, dmem_req_valid_o}, 32'h0);
            check("abort_wb_valid", {31'b0, wb_valid_o}, 32'h0);
            check("abort_stall", {31'b0, stall_o}, 32'h0);
        end

        // One more access after the abort proves the stage recovered
        @(posedge clk);
        #1;
        issue(1'b1, 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd2, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("mis_q_drained", mis_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
